// File: rtl/sar_search_4bit_pkg.sv
// Shared types and constants for the 4-bit successive-approximation search.
package sar_search_4bit_pkg;

  localparam int W          = 4;
  localparam int MAX_PROBES = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sar_search_4bit.sv
// Binary search over 0..15 driven by an external magnitude comparator.
// All outputs are registered; guess/busy/done are precomputed from next state
// so they are valid for the whole cycle the comparator is sampled in.
module sar_search_4bit
  import sar_search_4bit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_gt,
  input  logic         cmp_lt,
  input  logic         cmp_eq,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result,
  output logic [2:0]   probes
);

  state_e       state_q, state_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] guess_q, guess_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         found_q, found_d;
  logic         err_q, err_d;
  logic [W-1:0] result_q, result_d;
  logic [2:0]   probes_q, probes_d;
  logic [W:0]   sum_s;
  logic [W-1:0] guess_dec_s;
  logic [W-1:0] guess_inc_s;

  // Next-state, bound update and registered-output precomputation.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    probes_d    = probes_q;
    found_d     = found_q;
    err_d       = err_q;
    result_d    = result_q;
    guess_dec_s = guess_q - 4'd1;
    guess_inc_s = guess_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = 4'd0;
          hi_d     = 4'd15;
          probes_d = 3'd0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = 4'd0;
          state_d  = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        probes_d = probes_q + 3'd1;
        case ({cmp_gt, cmp_lt, cmp_eq})
          3'b001: begin
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = DONE;
          end
          3'b100: begin
            // Guess too high: shrink the upper bound; guard the wrap at 0.
            hi_d = guess_dec_s;
            if ((guess_q == 4'd0) || (guess_dec_s < lo_q)) begin
              state_d = DONE;
            end else begin
              state_d = SEARCH;
            end
          end
          3'b010: begin
            // Guess too low: raise the lower bound; guard the wrap at 15.
            lo_d = guess_inc_s;
            if ((guess_q == 4'd15) || (guess_inc_s > hi_q)) begin
              state_d = DONE;
            end else begin
              state_d = SEARCH;
            end
          end
          default: begin
            // None or several comparator bits set: inconsistent comparator.
            err_d   = 1'b1;
            found_d = 1'b0;
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // 5-bit sum so lo+hi never overflows before halving.
    sum_s   = {1'b0, lo_d} + {1'b0, hi_d};
    guess_d = (state_d == SEARCH) ? sum_s[W:1] : 4'd0;
    busy_d  = (state_d == SEARCH);
    done_d  = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= 4'd0;
      hi_q     <= 4'd15;
      guess_q  <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 4'd0;
      probes_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
      probes_q <= probes_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for sar_search_4bit with a behavioural comparator in the loop.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic [3:0] guess;
  logic       busy, done, found, err;
  logic [3:0] result;
  logic [2:0] probes;

  logic [3:0] target;
  logic       force_both;
  int         checks   = 0;
  int         failures = 0;

  sar_search_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit magnitude comparator: A = guess, B = target.
  always_comb begin
    cmp_gt = (guess > target);
    cmp_lt = (guess < target);
    cmp_eq = (guess == target);
    if (force_both) begin
      cmp_gt = 1'b1;
      cmp_lt = 1'b1;
      cmp_eq = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a search and check every probe plus the DONE cycle.
  // eg holds expected guesses, first probe in bits [3:0].
  task automatic run_search(input logic [3:0] tgt, input int n, input logic [19:0] eg,
                            input logic exp_found, input logic [3:0] exp_result);
    target = tgt;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("busy_t%0d_p%0d", tgt, i), 8'(busy), 8'd1);
      check($sformatf("guess_t%0d_p%0d", tgt, i), 8'(guess), 8'(eg[i*4 +: 4]));
      check($sformatf("done_lo_t%0d_p%0d", tgt, i), 8'(done), 8'd0);
      step();
    end
    check($sformatf("done_t%0d", tgt), 8'(done), 8'd1);
    check($sformatf("busy_off_t%0d", tgt), 8'(busy), 8'd0);
    check($sformatf("found_t%0d", tgt), 8'(found), 8'(exp_found));
    check($sformatf("result_t%0d", tgt), 8'(result), 8'(exp_result));
    check($sformatf("probes_t%0d", tgt), 8'(probes), 8'(n));
    check($sformatf("err_t%0d", tgt), 8'(err), 8'd0);
    check($sformatf("guess_done_t%0d", tgt), 8'(guess), 8'd0);
    step();
    check($sformatf("done_pulse_t%0d", tgt), 8'(done), 8'd0);
    check($sformatf("found_hold_t%0d", tgt), 8'(found), 8'(exp_found));
  endtask

  initial begin
    int waited;
    rst        = 1'b1;
    start      = 1'b0;
    target     = 4'd0;
    force_both = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_guess", 8'(guess), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_found", 8'(found), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    check("rst_result", 8'(result), 8'd0);
    check("rst_probes", 8'(probes), 8'd0);
    step();
    check("idle_nostart", 8'(busy), 8'd0);

    // Main searches
    run_search(4'd5, 3, {4'd0, 4'd0, 4'd5, 4'd3, 4'd7}, 1'b1, 4'd5);
    run_search(4'd15, 5, {4'd15, 4'd14, 4'd13, 4'd11, 4'd7}, 1'b1, 4'd15);
    run_search(4'd0, 4, {4'd0, 4'd0, 4'd1, 4'd3, 4'd7}, 1'b1, 4'd0);

    // Inconsistent comparator on the first probe
    force_both = 1'b1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    check("err_busy", 8'(busy), 8'd1);
    check("err_guess", 8'(guess), 8'd7);
    step();
    force_both = 1'b0;
    check("err_done", 8'(done), 8'd1);
    check("err_flag", 8'(err), 8'd1);
    check("err_found", 8'(found), 8'd0);
    check("err_probes", 8'(probes), 8'd1);
    step();
    check("err_hold", 8'(err), 8'd1);
    check("err_result", 8'(result), 8'd0);

    // Reset during the second SEARCH cycle aborts without a done pulse
    target = 4'd9;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("abort_g1", 8'(guess), 8'd7);
    step();
    check("abort_g2", 8'(guess), 8'd11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_done", 8'(done), 8'd0);
    check("abort_guess", 8'(guess), 8'd0);
    check("abort_found", 8'(found), 8'd0);
    check("abort_err", 8'(err), 8'd0);
    check("abort_result", 8'(result), 8'd0);
    check("abort_probes", 8'(probes), 8'd0);
    step();
    check("abort_nodone", 8'(done), 8'd0);
    run_search(4'd9, 3, {4'd0, 4'd0, 4'd9, 4'd11, 4'd7}, 1'b1, 4'd9);

    // start held high: one search, one done, restart only from IDLE
    target = 4'd4;
    start  = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_busy_p%0d", i), 8'(busy), 8'd1);
      check($sformatf("hold_done_p%0d", i), 8'(done), 8'd0);
      step();
    end
    check("hold_done", 8'(done), 8'd1);
    check("hold_result", 8'(result), 8'd4);
    check("hold_probes", 8'(probes), 8'd4);
    step();
    check("hold_idle_busy", 8'(busy), 8'd0);
    check("hold_idle_done", 8'(done), 8'd0);
    step();
    check("hold_restart_busy", 8'(busy), 8'd1);
    check("hold_restart_guess", 8'(guess), 8'd7);
    check("hold_restart_found", 8'(found), 8'd0);
    start  = 1'b0;
    waited = 0;
    while (!done && waited < 10) begin
      step();
      waited++;
    end
    check("hold2_timeout", 8'(done), 8'd1);
    check("hold2_found", 8'(found), 8'd1);
    check("hold2_result", 8'(result), 8'd4);
    check("hold2_probes", 8'(probes), 8'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_search_4bit.md
SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cmp_gt  input  1  external comparator result: guess > hidden target.
REQ-006 cmp_lt  input  1  external comparator result: guess < hidden target.
REQ-007 cmp_eq  input  1  external comparator result: guess == hidden target.
REQ-008 guess  output  4  current probe value driven to the comparator A input.
REQ-009 busy  output  1  high in SEARCH.
REQ-010 done  output  1  one-cycle pulse in DONE.
REQ-011 found  output  1  target located; held until next accepted start.
REQ-012 err  output  1  inconsistent comparator input detected; held until next accepted start.
REQ-013 result  output  4  located value (valid when found=1); held until next accepted start.
REQ-014 probes  output  3  number of comparisons made in the last or current search (0..5).

Function
REQ-015 The FSM SHALL have three states: IDLE, SEARCH and DONE.
REQ-016 IDLE: start=1 SHALL load lo=0, hi=15, probes=0, and clear found, err and result, then go to SEARCH next cycle.
REQ-017 In SEARCH, guess SHALL equal (lo+hi)>>1, using a 5-bit sum so there is no overflow; in IDLE and DONE, guess SHALL be 0.
REQ-018 Each SEARCH cycle SHALL sample cmp_* once and increment probes by 1.
REQ-019 On cmp_eq only, the block SHALL set result=guess and found=1, then go to DONE.
REQ-020 On cmp_gt only, the block SHALL set hi=guess-1; if guess==0 or the new hi<lo, it SHALL go to DONE with found=0.
REQ-021 On cmp_lt only, the block SHALL set lo=guess+1; if guess==15 or the new lo>hi, it SHALL go to DONE with found=0.
REQ-022 If zero or more than one cmp_* bit is high in SEARCH, the block SHALL set err=1 and found=0, then go to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-024 start SHALL be ignored in SEARCH and DONE; it is not queued.
REQ-025 With a consistent comparator, a search SHALL complete in at most 5 probes; the latency from start to the done pulse is probes+1 cycles.
REQ-026 cmp_* inputs SHALL be ignored outside SEARCH.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE with guess=0, busy=0, done=0, found=0, err=0, result=0, probes=0, lo=0 and hi=15.
REQ-028 Reset SHALL take priority over start and over an in-progress search; a search aborted by reset SHALL produce no done pulse.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, SEARCH, DONE), the constant W=4 and the constant MAX_PROBES=5.
REQ-030 The block SHALL be a single module with no sub-module; the midpoint computation stays inline.
REQ-031 The bench SHALL close the loop with a behavioural 4-bit magnitude comparator: A=guess, B=target.

Verification
REQ-032 Target 5, start pulse at cycle 0 -> guesses 7, 3, 5 in cycles 1-3; done=1 at cycle 4 with found=1, result=5, probes=3.
REQ-033 Target 15 -> guesses 7, 11, 13, 14, 15; found=1, result=15, probes=5, done 6 cycles after start.
REQ-034 Target 0 -> guesses 7, 3, 1, 0; found=1, result=0, probes=4.
REQ-035 Comparator forced to cmp_gt=1 and cmp_lt=1 on the first probe -> done at cycle 2 with err=1, found=0, probes=1.
REQ-036 Target 9, rst=1 during the second SEARCH cycle -> next cycle in IDLE with all outputs 0 and no done pulse; a new start then finds 9.
REQ-037 start held high throughout a search for target 4 -> exactly one search and one done pulse; the second search begins only from IDLE.
